// File: rtl/hu_pipeline_skid.sv
// hu_pipeline_skid
//   Two-entry elastic stage (main + skid register) with a valid/ready
//   handshake. Every output is registered, and there is no combinational
//   path from out_ready to in_ready, so a stalling consumer can be
//   decoupled from a stalling producer.
//
// Ports
//   clk        pipeline clock, rising edge
//   rst        synchronous reset, active-high (highest priority)
//   flush      synchronous discard of all held words
//   in_data    upstream word, sampled only on an input transfer
//   in_valid   upstream word present
//   in_ready   stage can accept a word this cycle
//   out_data   oldest held word (main register)
//   out_valid  out_data holds a valid word
//   out_ready  downstream accepts out_data this cycle
//   level      number of words held (0..2)
module hu_pipeline_skid #(
    parameter type regtype = logic [7:0]
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  regtype     in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output regtype     out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t     state;
    regtype     main_q;
    regtype     skid_q;
    logic       out_valid_q;
    logic       in_ready_q;
    logic [1:0] level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            level_q     <= 2'd0;
        end else if (flush) begin
            // Words offered on this edge are dropped; data registers keep
            // their stale contents since out_valid masks them.
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            level_q     <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        main_q      <= in_data;
                        state       <= BUSY;
                        out_valid_q <= 1'b1;
                        level_q     <= 2'd1;
                    end
                end
                BUSY: begin
                    if (in_valid && out_ready) begin
                        main_q <= in_data;
                    end else if (in_valid) begin
                        skid_q     <= in_data;
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                        level_q    <= 2'd2;
                    end else if (out_ready) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                        level_q     <= 2'd0;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        main_q     <= skid_q;
                        state      <= BUSY;
                        in_ready_q <= 1'b1;
                        level_q    <= 2'd1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    level_q     <= 2'd0;
                end
            endcase
        end
    end

    // in_ready_q is pre-set to 1 while rst is held so the stage is ready the
    // first cycle after rst drops; the rst gate keeps it low during reset.
    assign in_ready  = in_ready_q & ~rst;
    assign out_data  = main_q;
    assign out_valid = out_valid_q;
    assign level     = level_q;

endmodule

// File: doc/hu_pipeline_skid.md
Name: hu_pipeline_skid

Overview:
- Two-entry elastic stage with valid/ready handshake and skid buffer.
- Sits directly upstream of the fixed-latency pipeline register chain. It absorbs back-pressure so that in_ready and all outputs are registered, with no combinational ready path from out_ready to in_ready.
- Used wherever a stalling producer feeds a hu_pipeline_reg chain or a stalling consumer.

Parameters:
- regtype, bit[7:0], type of the data word carried.

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous clear of buffered data; lower priority than rst.
- in_data  input  regtype  upstream data word.
- in_valid  input  1  upstream word present.
- in_ready  output  1  stage can accept a word this cycle (registered).
- out_data  output  regtype  word presented downstream (registered).
- out_valid  output  1  out_data holds a valid word (registered).
- out_ready  input  1  downstream accepts the word this cycle.
- level  output  2  number of words held: 0, 1 or 2.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst).
- Transfers:
  - Input transfer when in_valid and in_ready are both high at a rising edge.
  - Output transfer when out_valid and out_ready are both high at a rising edge.
- Storage: main register (drives out_data) and skid register.
- States:
  - EMPTY: level 0.
  - BUSY: main full, level 1.
  - FULL: main and skid full, level 2.
- Outputs per state:
  - in_ready = (state != FULL) and not in reset.
  - out_valid = (state != EMPTY).
  - level follows state.
- EMPTY transitions:
  - in_valid -> load main from in_data, go BUSY.
  - otherwise stay EMPTY.
- BUSY transitions:
  - in_valid and out_ready -> load main, stay BUSY (throughput 1 word/cycle).
  - in_valid and not out_ready -> load skid, go FULL.
  - not in_valid and out_ready -> go EMPTY.
  - neither -> hold.
- FULL transitions:
  - out_ready -> main <= skid, go BUSY.
  - otherwise hold. No input is accepted (in_ready=0), so in_valid is ignored.
- Latency: a word accepted at edge N is on out_data/out_valid after edge N, when it is the oldest word held.
- Ordering: strict FIFO; no word dropped or duplicated.
- Data stability: while out_valid=1 and out_ready=0, out_data is held constant.
- Reset (rst=1 at edge), effective the cycle after:
  - state EMPTY, out_valid=0, out_data='0, skid='0, level=0.
  - in_ready=0 during any cycle rst is high; in_ready=1 the first cycle after rst drops.
  - Reset mid-operation discards both words with no output transfer.
- Flush (flush=1, rst=0 at edge):
  - state EMPTY, out_valid=0, level=0; data registers need not clear.
  - An input offered on the same edge is discarded, not accepted.
  - An output transfer on the same edge still counts as consumed by downstream.
- Priority: rst > flush > normal operation.
- in_data is sampled only on input transfers; X on in_data while in_valid=0 must not propagate.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, level=0 throughout; in_ready=1 the cycle after rst falls.
- Streaming: out_ready=1, push 0x01..0x10 back-to-back -> out_data 0x01..0x10 in order, one per cycle, 1-cycle latency, level stays 1.
- Stall/skid: push 0xA1, 0xA2, 0xA3 with out_ready=0 -> level 1 then 2, in_ready drops after 0xA2 and 0xA3 is not accepted. Raise out_ready -> outputs 0xA1, 0xA2, then 0xA3 after it is re-offered; out_data is stable while stalled.
- Random back-pressure: 1000 words with random in_valid/out_ready at 50% -> scoreboard matches exactly, no loss or duplication, level never exceeds 2.
- Flush in FULL with 0xB1/0xB2 held and in_valid=1 carrying 0xB3 -> next cycle level=0, out_valid=0. No word 0xB1–0xB3 ever appears; next pushed word 0xC0 emerges first.
- Mid-operation reset in FULL -> all words discarded, out_data=0, and normal flow resumes.
